multicycle_control: RTL and testbench

- Multicycle successor to the single-cycle RV32I decoder: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Sits between the instruction register and the shared datapath (ALU, register file, unified instruction/data memory).
- Adds a memory-ready handshake, branch evaluation, and illegal-opcode flagging.
- Supported opcodes: lw, sw, R-type, I-type ALU, branch, jal, lui.

---
 rtl/multicycle_control_pkg.sv | 75 +++++++
 rtl/multicycle_control_alu_decoder.sv | 47 ++++
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle RV32I control unit:
// FSM states, opcodes, ALU operation codes and immediate formats.
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXEC_R   = 4'd6,
      S_EXEC_I   = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_ILLEGAL  = 4'd12
   } state_t;

   // Which family of operations the ALU decoder should pick from.
   typedef enum logic [2:0] {
      CLS_ADD    = 3'd0,
      CLS_RTYPE  = 3'd1,
      CLS_ITYPE  = 3'd2,
      CLS_BRANCH = 3'd3,
      CLS_PASSB  = 3'd4
   } alu_cls_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_SLL    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_SLT    = 4'd8;
   localparam logic [3:0] ALU_SLTU   = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   // Branch outcome from the comparison flags; reserved func3 never branches.
   function automatic logic branch_taken(input logic [2:0] f3,
                                         input logic       zero,
                                         input logic       last);
      logic taken;
      case (f3)
         3'b000:         taken = zero;
         3'b001:         taken = ~zero;
         3'b100, 3'b110: taken = last;
         3'b101, 3'b111: taken = ~last;
         default:        taken = 1'b0;
      endcase
      return taken;
   endfunction

   function automatic logic branch_f3_illegal(input logic [2:0] f3);
      return (f3[2:1] == 2'b01);
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU operation select from the sequencer's operation class
// and the instruction's func3 / func7[5] fields.
module alu_decoder
   import multicycle_pkg::*;
(
   input  alu_cls_t   alu_cls_i,
   input  logic [2:0] func3_i,
   input  logic       func7_5_i,
   output logic [3:0] alu_op_o
);

   logic sub_en_s;

   // Only register-register ops may turn func3=000 into SUB; ADDI ignores func7.
   assign sub_en_s = (alu_cls_i == CLS_RTYPE) & func7_5_i;

   // Operation select.
   always_comb begin
      alu_op_o = ALU_ADD;
      case (alu_cls_i)
         CLS_ADD:   alu_op_o = ALU_ADD;
         CLS_PASSB: alu_op_o = ALU_PASS_B;
         CLS_BRANCH: begin
            case (func3_i[2:1])
               2'b10:   alu_op_o = ALU_SLT;
               2'b11:   alu_op_o = ALU_SLTU;
               default: alu_op_o = ALU_SUB;
            endcase
         end
         CLS_RTYPE, CLS_ITYPE: begin
            case (func3_i)
               3'b000:  alu_op_o = sub_en_s ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op_o = ALU_SLL;
               3'b010:  alu_op_o = ALU_SLT;
               3'b011:  alu_op_o = ALU_SLTU;
               3'b100:  alu_op_o = ALU_XOR;
               3'b101:  alu_op_o = func7_5_i ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op_o = ALU_OR;
               3'b111:  alu_op_o = ALU_AND;
               default: alu_op_o = ALU_ADD;
            endcase
         end
         default: alu_op_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback, with a memory-ready handshake and illegal-opcode flagging.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter int IMM_SRC_W   = 3,
   parameter int MEM_WAIT_EN = 1
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            op,
   input  logic [2:0]            func3,
   input  logic [6:0]            func7,
   input  logic                  alu_zero,
   input  logic                  alu_last_bit,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  ir_write,
   output logic                  adr_source,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  reg_write,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            result_src,
   output logic [IMM_SRC_W-1:0]  imm_source,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  illegal_instr,
   output logic [3:0]            state_dbg
);

   localparam logic WAIT_EN = (MEM_WAIT_EN != 0);

   state_t     state_q, state_d;
   alu_cls_t   alu_cls_s;
   logic [3:0] alu_op_s;
   logic       mem_rdy_s;
   logic       pc_write_s, ir_write_s, adr_source_s, mem_read_s;
   logic       mem_write_s, reg_write_s, illegal_s;
   logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s;
   logic [2:0] imm_s;
   logic       unused_func7_s;

   assign mem_rdy_s      = WAIT_EN ? mem_ready : 1'b1;
   assign unused_func7_s = ^{func7[6], func7[4:0]};

   // State register; reset lands in FETCH and drops any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode.
   always_comb begin
      state_d      = state_q;
      pc_write_s   = 1'b0;
      ir_write_s   = 1'b0;
      adr_source_s = 1'b0;
      mem_read_s   = 1'b0;
      mem_write_s  = 1'b0;
      reg_write_s  = 1'b0;
      illegal_s    = 1'b0;
      alu_src_a_s  = 2'd0;
      alu_src_b_s  = 2'd0;
      result_src_s = 2'd0;
      imm_s        = IMM_I;
      alu_cls_s    = CLS_ADD;
      case (state_q)
         S_FETCH: begin
            mem_read_s  = 1'b1;
            alu_src_b_s = 2'd2;
            if (mem_rdy_s) begin
               ir_write_s = 1'b1;
               pc_write_s = 1'b1;
               state_d    = S_DECODE;
            end else begin
               state_d    = S_FETCH;
            end
         end
         S_DECODE: begin
            // Precompute the branch/jump target into the ALU-out register.
            alu_src_a_s = 2'd1;
            alu_src_b_s = 2'd1;
            imm_s       = (op == OP_JAL) ? IMM_J : IMM_B;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXEC_R;
               OP_ITYPE:          state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = S_LUI;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_s = 2'd2;
            alu_src_b_s = 2'd1;
            imm_s       = (op == OP_STORE) ? IMM_S : IMM_I;
            state_d     = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_read_s   = 1'b1;
            adr_source_s = 1'b1;
            state_d      = mem_rdy_s ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            reg_write_s  = 1'b1;
            result_src_s = 2'd1;
            state_d      = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_write_s  = 1'b1;
            adr_source_s = 1'b1;
            state_d      = mem_rdy_s ? S_FETCH : S_MEMWRITE;
         end
         S_EXEC_R: begin
            alu_src_a_s = 2'd2;
            alu_cls_s   = CLS_RTYPE;
            state_d     = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a_s = 2'd2;
            alu_src_b_s = 2'd1;
            alu_cls_s   = CLS_ITYPE;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            state_d     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_s = 2'd2;
            alu_cls_s   = CLS_BRANCH;
            pc_write_s  = branch_taken(func3, alu_zero, alu_last_bit);
            illegal_s   = branch_f3_illegal(func3);
            state_d     = S_FETCH;
         end
         S_JAL: begin
            // PC takes the DECODE target; rd takes old PC + 4 off the live ALU.
            alu_src_a_s = 2'd1;
            alu_src_b_s = 2'd2;
            pc_write_s  = 1'b1;
            reg_write_s = 1'b1;
            state_d     = S_FETCH;
         end
         S_LUI: begin
            alu_src_b_s = 2'd1;
            imm_s       = IMM_U;
            alu_cls_s   = CLS_PASSB;
            state_d     = S_ALUWB;
         end
         S_ILLEGAL: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_cls_i (alu_cls_s),
      .func3_i   (func3),
      .func7_5_i (func7[5]),
      .alu_op_o  (alu_op_s)
   );

   // While reset is held only the fetch read request is visible, whatever mem_ready does.
   assign pc_write      = rst_n & pc_write_s;
   assign ir_write      = rst_n & ir_write_s;
   assign adr_source    = rst_n & adr_source_s;
   assign mem_read      = rst_n ? mem_read_s : 1'b1;
   assign mem_write     = rst_n & mem_write_s;
   assign reg_write     = rst_n & reg_write_s;
   assign illegal_instr = rst_n & illegal_s;
   assign alu_src_a     = rst_n ? alu_src_a_s  : 2'd0;
   assign alu_src_b     = rst_n ? alu_src_b_s  : 2'd0;
   assign result_src    = rst_n ? result_src_s : 2'd0;
   assign imm_source    = rst_n ? IMM_SRC_W'(imm_s)     : '0;
   assign alu_control   = rst_n ? ALU_CTRL_W'(alu_op_s) : '0;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each instruction expands into a
// per-cycle list of expected control outputs that a compare process checks.
module tb_multicycle_control;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] LU  = 7'b0110111;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct packed {
      logic [3:0] st;
      logic       rdy;
      logic       pcw, irw, adr, mrd, mwr, rgw, ill;
      logic [1:0] a, b, res;
      logic [2:0] imm;
      logic [3:0] alu;
   } exp_t;

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       zero, last;
      logic [3:0] fw, mw;
      logic [3:0] alu;
      logic       taken, ill;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       alu_zero, alu_last_bit, mem_ready;
   logic       pc_write, ir_write, adr_source, mem_read, mem_write, reg_write;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [2:0] imm_source;
   logic [3:0] alu_control;
   logic       illegal_instr;
   logic [3:0] state_dbg;

   int   n_cmp = 0;
   int   n_err = 0;
   int   ill_cnt = 0;
   int   mw_cnt = 0;
   int   rw_cnt = 0;
   exp_t exp_cur;
   logic exp_valid = 1'b0;
   exp_t plan[$];

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .op(op), .func3(func3), .func7(func7),
      .alu_zero(alu_zero), .alu_last_bit(alu_last_bit), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .adr_source(adr_source),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .imm_source(imm_source), .alu_control(alu_control),
      .illegal_instr(illegal_instr), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Expected outputs of one cycle, read straight off the state's description.
   function automatic exp_t exp_for(input logic [3:0] st, input logic rdy, input vec_t v);
      exp_t e;
      e = '0;
      e.st  = st;
      e.rdy = rdy;
      case (st)
         4'd0:  begin e.mrd = 1'b1; e.b = 2'd2; e.pcw = rdy; e.irw = rdy; end
         4'd1:  begin e.a = 2'd1; e.b = 2'd1; e.imm = (v.op == JL) ? 3'd3 : 3'd2; end
         4'd2:  begin e.a = 2'd2; e.b = 2'd1; e.imm = (v.op == SW) ? 3'd1 : 3'd0; end
         4'd3:  begin e.mrd = 1'b1; e.adr = 1'b1; end
         4'd4:  begin e.rgw = 1'b1; e.res = 2'd1; end
         4'd5:  begin e.mwr = 1'b1; e.adr = 1'b1; end
         4'd6:  begin e.a = 2'd2; e.alu = v.alu; end
         4'd7:  begin e.a = 2'd2; e.b = 2'd1; e.alu = v.alu; end
         4'd8:  begin e.rgw = 1'b1; end
         4'd9:  begin e.a = 2'd2; e.alu = v.alu; e.pcw = v.taken; e.ill = v.ill; end
         4'd10: begin e.a = 2'd1; e.b = 2'd2; e.pcw = 1'b1; e.rgw = 1'b1; end
         4'd11: begin e.b = 2'd1; e.imm = 3'd4; e.alu = 4'd10; end
         4'd12: begin e.ill = 1'b1; end
         default: e.st = 4'd0;
      endcase
      return e;
   endfunction

   function automatic vec_t mkv(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                input logic z, input logic l, input logic [3:0] fw,
                                input logic [3:0] mw, input logic [3:0] alu,
                                input logic tk, input logic il);
      vec_t v;
      v = '{op:o, f3:f3, f7:f7, zero:z, last:l, fw:fw, mw:mw, alu:alu, taken:tk, ill:il};
      return v;
   endfunction

   // Compare DUT against the current expectation on the falling edge.
   always @(negedge clk) begin
      if (exp_valid) begin
         check("state_dbg",     state_dbg,     exp_cur.st);
         check("pc_write",      pc_write,      exp_cur.pcw);
         check("ir_write",      ir_write,      exp_cur.irw);
         check("adr_source",    adr_source,    exp_cur.adr);
         check("mem_read",      mem_read,      exp_cur.mrd);
         check("mem_write",     mem_write,     exp_cur.mwr);
         check("reg_write",     reg_write,     exp_cur.rgw);
         check("illegal_instr", illegal_instr, exp_cur.ill);
         check("alu_src_a",     alu_src_a,     exp_cur.a);
         check("alu_src_b",     alu_src_b,     exp_cur.b);
         check("result_src",    result_src,    exp_cur.res);
         check("imm_source",    imm_source,    exp_cur.imm);
         check("alu_control",   alu_control,   exp_cur.alu);
         if (illegal_instr === 1'b1) ill_cnt++;
         if (mem_write === 1'b1) mw_cnt++;
         if (reg_write === 1'b1) rw_cnt++;
      end
   end

   task automatic run_plan();
      while (plan.size() > 0) begin
         exp_cur   = plan.pop_front();
         mem_ready = exp_cur.rdy;
         exp_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      exp_valid = 1'b0;
   endtask

   // Expand one instruction into its cycle-by-cycle expectation and run it.
   task automatic run_vec(input vec_t v);
      op = v.op; func3 = v.f3; func7 = v.f7;
      alu_zero = v.zero; alu_last_bit = v.last;
      for (int i = 0; i < int'(v.fw); i++) plan.push_back(exp_for(4'd0, 1'b0, v));
      plan.push_back(exp_for(4'd0, 1'b1, v));
      plan.push_back(exp_for(4'd1, 1'b1, v));
      case (v.op)
         LW: begin
            plan.push_back(exp_for(4'd2, 1'b1, v));
            for (int i = 0; i < int'(v.mw); i++) plan.push_back(exp_for(4'd3, 1'b0, v));
            plan.push_back(exp_for(4'd3, 1'b1, v));
            plan.push_back(exp_for(4'd4, 1'b1, v));
         end
         SW: begin
            plan.push_back(exp_for(4'd2, 1'b1, v));
            for (int i = 0; i < int'(v.mw); i++) plan.push_back(exp_for(4'd5, 1'b0, v));
            plan.push_back(exp_for(4'd5, 1'b1, v));
         end
         RT: begin plan.push_back(exp_for(4'd6, 1'b1, v)); plan.push_back(exp_for(4'd8, 1'b1, v)); end
         IT: begin plan.push_back(exp_for(4'd7, 1'b1, v)); plan.push_back(exp_for(4'd8, 1'b1, v)); end
         BR: plan.push_back(exp_for(4'd9, 1'b1, v));
         JL: plan.push_back(exp_for(4'd10, 1'b1, v));
         LU: begin plan.push_back(exp_for(4'd11, 1'b1, v)); plan.push_back(exp_for(4'd8, 1'b1, v)); end
         default: plan.push_back(exp_for(4'd12, 1'b1, v));
      endcase
      run_plan();
   endtask

   vec_t vecs[$];
   int   snap;

   initial begin
      rst_n = 1'b0; mem_ready = 1'b1; op = LW; func3 = 3'b010; func7 = 7'd0;
      alu_zero = 1'b0; alu_last_bit = 1'b0;
      #2;
      check("rst state_dbg", state_dbg, 32'd0);
      check("rst mem_read",  mem_read,  32'd1);
      check("rst pc_write",  pc_write,  32'd0);
      check("rst ir_write",  ir_write,  32'd0);
      check("rst alu_src_b", alu_src_b, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      //        op   f3      f7          z     l     fw    mw    alu   tk    il
      vecs.push_back(mkv(LW, 3'b010, 7'b0000000, 1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0));
      vecs.push_back(mkv(LW, 3'b010, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0));
      vecs.push_back(mkv(RT, 3'b000, 7'b0100000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0));
      vecs.push_back(mkv(RT, 3'b101, 7'b0100000, 1'b0, 1'b0, 4'd1, 4'd0, 4'd7, 1'b0, 1'b0));
      vecs.push_back(mkv(RT, 3'b000, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      vecs.push_back(mkv(RT, 3'b111, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0));
      vecs.push_back(mkv(RT, 3'b011, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 1'b0, 1'b0));
      vecs.push_back(mkv(IT, 3'b000, 7'b0100000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      vecs.push_back(mkv(IT, 3'b101, 7'b0100000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0));
      vecs.push_back(mkv(IT, 3'b101, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0));
      vecs.push_back(mkv(IT, 3'b100, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0));
      vecs.push_back(mkv(BR, 3'b000, 7'b0000000, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0));
      vecs.push_back(mkv(BR, 3'b001, 7'b0000000, 1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0));
      vecs.push_back(mkv(BR, 3'b101, 7'b0000000, 1'b0, 1'b1, 4'd0, 4'd0, 4'd8, 1'b0, 1'b0));
      vecs.push_back(mkv(BR, 3'b100, 7'b0000000, 1'b0, 1'b1, 4'd0, 4'd0, 4'd8, 1'b1, 1'b0));
      vecs.push_back(mkv(BR, 3'b110, 7'b0000000, 1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0));
      vecs.push_back(mkv(BR, 3'b111, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0));
      vecs.push_back(mkv(BR, 3'b010, 7'b0000000, 1'b1, 1'b1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b1));
      vecs.push_back(mkv(JL, 3'b000, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      vecs.push_back(mkv(LU, 3'b000, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      foreach (vecs[i]) run_vec(vecs[i]);

      snap = mw_cnt;
      run_vec(mkv(SW, 3'b010, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0));
      check("sw mem_write cycles", mw_cnt - snap, 32'd3);

      snap = rw_cnt;
      run_vec(mkv(LW, 3'b010, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      check("lw reg_write cycles", rw_cnt - snap, 32'd1);

      snap = ill_cnt;
      run_vec(mkv(BAD, 3'b000, 7'b0000000, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      check("illegal pulse cycles", ill_cnt - snap, 32'd1);

      // Reset while a load is waiting in MEMREAD.
      op = LW; func3 = 3'b010;
      plan.push_back(exp_for(4'd0, 1'b1, vecs[0]));
      plan.push_back(exp_for(4'd1, 1'b1, vecs[0]));
      plan.push_back(exp_for(4'd2, 1'b1, vecs[0]));
      plan.push_back(exp_for(4'd3, 1'b0, vecs[0]));
      plan.push_back(exp_for(4'd3, 1'b0, vecs[0]));
      run_plan();
      check("pre-reset state", state_dbg, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst state",  state_dbg,  32'd0);
      check("async rst adr",    adr_source, 32'd0);
      check("async rst rdreq",  mem_read,   32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_vec(mkv(RT, 3'b110, 7'b0000000, 1'b0, 1'b0, 4'd1, 4'd0, 4'd3, 1'b0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
